// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal register: hold/load/shift/rotate/asr/clear
// Single-cycle update on rising i_clk when i_en=1; o_zero and o_parity follow o_q combinationally.
module univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_async_reset,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin_l,
  input  logic             i_sin_r,
  output logic [WIDTH-1:0] o_q,
  output logic             o_shout,
  output logic             o_zero,
  output logic             o_parity
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_shout;
  logic [WIDTH-1:0] w_next_q;
  logic             w_next_shout;
  mode_e            w_mode;

  assign w_mode = mode_e'(i_mode);

  generate
    if (WIDTH == 1) begin : g_single
      // A one-bit register has nothing to rotate, so ROTL/ROTR/ASR keep q.
      always_comb begin
        w_next_q     = r_q;
        w_next_shout = r_shout;
        case (w_mode)
          MODE_HOLD: begin
          end
          MODE_LOAD: begin
            w_next_q     = i_d;
            w_next_shout = 1'b0;
          end
          MODE_SHL: begin
            w_next_q     = i_sin_l;
            w_next_shout = r_q[0];
          end
          MODE_SHR: begin
            w_next_q     = i_sin_r;
            w_next_shout = r_q[0];
          end
          MODE_ROTL, MODE_ROTR: begin
          end
          MODE_ASR: begin
            w_next_shout = r_q[0];
          end
          MODE_CLEAR: begin
            w_next_q     = RESET_VAL;
            w_next_shout = 1'b0;
          end
        endcase
      end
    end else begin : g_multi
      always_comb begin
        w_next_q     = r_q;
        w_next_shout = r_shout;
        case (w_mode)
          MODE_HOLD: begin
          end
          MODE_LOAD: begin
            w_next_q     = i_d;
            w_next_shout = 1'b0;
          end
          MODE_SHL: begin
            w_next_q     = {r_q[WIDTH-2:0], i_sin_l};
            w_next_shout = r_q[WIDTH-1];
          end
          MODE_SHR: begin
            w_next_q     = {i_sin_r, r_q[WIDTH-1:1]};
            w_next_shout = r_q[0];
          end
          MODE_ROTL: begin
            w_next_q     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          end
          MODE_ROTR: begin
            w_next_q     = {r_q[0], r_q[WIDTH-1:1]};
          end
          MODE_ASR: begin
            w_next_q     = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            w_next_shout = r_q[0];
          end
          MODE_CLEAR: begin
            w_next_q     = RESET_VAL;
            w_next_shout = 1'b0;
          end
        endcase
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_async_reset) begin
    if (i_async_reset) begin
      r_q     <= RESET_VAL;
      r_shout <= 1'b0;
    end else if (i_en) begin
      r_q     <= w_next_q;
      r_shout <= w_next_shout;
    end
  end

  assign o_q      = r_q;
  assign o_shout  = r_shout;
  assign o_zero   = (r_q == '0);
  assign o_parity = ^r_q;

endmodule
